slow_pulse_driver: RTL and testbench

- Output-side partner of the slow-input deglitch stage.
- Drives a single slow external control line, such as a shutter or trigger line, with clean, glitch-free pulses.
- Each pulse has a programmable high duration, followed by an enforced minimum idle time, so the far-end deglitcher always sees stable levels.
- Sits between a control FSM, which issues pulse requests over a valid/ready handshake, and the output pad.

---
 rtl/slow_io_pkg.sv | 17 +
 rtl/slow_down_counter.sv | 27 ++
 rtl/slow_pulse_driver.sv | 97 +++++++++
 tb/tb_slow_pulse_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/slow_io_pkg.sv
// Shared definitions for the slow external-line blocks: state encoding and default counter width.
package slow_io_pkg;

    localparam int SLOW_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        GUARD = 2'd2
    } slow_state_e;

    // A requested width of zero still produces a one-cycle pulse.
    function automatic int unsigned eff_width(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/slow_down_counter.sv
// Loadable down-counter with zero flag, shared between the active and guard phases of the pulse driver.
module slow_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && !zero) begin
            // Holding at zero keeps the counter from ever wrapping.
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/slow_pulse_driver.sv
// Glitch-free pulse generator for a slow external control line: programmable active width, then a fixed idle guard.
// Optional abort input enabled by defining SLOW_PULSE_DRIVER_ABORT_EN.
module slow_pulse_driver
    import slow_io_pkg::*;
#(
    parameter int   CNT_W      = SLOW_CNT_W_DEFAULT,
    parameter int   MIN_LOW    = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] width,
`ifdef SLOW_PULSE_DRIVER_ABORT_EN
    input  logic             abort,
`endif
    output logic             out,
    output logic             busy,
    output logic             done
);

    if (MIN_LOW < 1) begin : g_min_low_check
        $error("slow_pulse_driver: MIN_LOW must be >= 1");
    end

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(MIN_LOW - 1);

    slow_state_e      state, state_n;
    logic             cnt_load, cnt_en, cnt_zero, done_n, abort_hit;
    logic [CNT_W-1:0] cnt_val, cnt;

`ifdef SLOW_PULSE_DRIVER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    slow_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_val),
        .en         (cnt_en),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    assign start_ready = (state == IDLE) && !rst;
    assign busy        = (state == HIGH) || (state == GUARD);

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_n  = HIGH;
                    cnt_load = 1'b1;
                    cnt_val  = (width == '0) ? '0 : width - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_zero || abort_hit) begin
                    state_n  = GUARD;
                    cnt_load = 1'b1;
                    cnt_val  = GUARD_LOAD;
                    done_n   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_zero) state_n = IDLE;
                else          cnt_en  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // out is registered from the next state so it changes in step with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= IDLE_LEVEL;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            out   <= (state_n == HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_slow_pulse_driver.sv
// Directed, table-driven bench for slow_pulse_driver (CNT_W=4, MIN_LOW=4), both idle polarities.
module tb_slow_pulse_driver;
    import slow_io_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic             rst;
        logic             valid;
        logic [CNT_W-1:0] width;
        logic             abort;
        logic             act;
        logic             busy;
        logic             done;
        logic             ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start_valid, abort;
    logic [CNT_W-1:0] width;
    logic rdy0, out0, busy0, done0;
    logic rdy1, out1, busy1, done1;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    slow_pulse_driver #(.CNT_W(CNT_W), .MIN_LOW(4), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy0), .width(width),
`ifdef SLOW_PULSE_DRIVER_ABORT_EN
        .abort(abort),
`endif
        .out(out0), .busy(busy0), .done(done0)
    );

    slow_pulse_driver #(.CNT_W(CNT_W), .MIN_LOW(4), .IDLE_LEVEL(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy1), .width(width),
`ifdef SLOW_PULSE_DRIVER_ABORT_EN
        .abort(abort),
`endif
        .out(out1), .busy(busy1), .done(done1)
    );

    task automatic v(input logic r, input logic vl, input int w, input logic ab,
                     input logic act, input logic b, input logic d, input logic rd);
        vec_t x;
        x.rst = r; x.valid = vl; x.width = CNT_W'(w); x.abort = ab;
        x.act = act; x.busy = b; x.done = d; x.ready = rd;
        vq.push_back(x);
    endtask

    // n cycles of the same vector
    task automatic rep(input int n, input logic vl, input int w,
                       input logic act, input logic b, input logic rd);
        for (int i = 0; i < n; i++) v(1'b0, vl, w, 1'b0, act, b, 1'b0, rd);
    endtask

    task automatic chk(input string name, input int idx, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, a, e);
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; width = '0; abort = 1'b0;
        repeat (2) @(posedge clk);

        // reset held, then a single width=5 pulse
        v(1,0,0,0, 0,0,0,0); v(1,0,0,0, 0,0,0,0); v(1,0,0,0, 0,0,0,0);
        v(0,1,5,0, 0,0,0,1);
        rep(5, 0,0, 1,1,0);
        v(0,0,0,0, 0,1,1,0);
        rep(3, 0,0, 0,1,0);
        v(0,0,0,0, 0,0,0,1);

        // width=0 -> one active cycle
        v(0,1,0,0, 0,0,0,1);
        rep(1, 0,0, 1,1,0);
        v(0,0,0,0, 0,1,1,0);
        rep(3, 0,0, 0,1,0);
        v(0,0,0,0, 0,0,0,1);

        // maximum width 15
        v(0,1,15,0, 0,0,0,1);
        rep(15, 0,0, 1,1,0);
        v(0,0,0,0, 0,1,1,0);
        rep(3, 0,0, 0,1,0);
        v(0,0,0,0, 0,0,0,1);

        // back-to-back, valid held: 2 active, 5 idle, 2 active
        v(0,1,2,0, 0,0,0,1);
        rep(2, 1,2, 1,1,0);
        v(0,1,2,0, 0,1,1,0);
        rep(3, 1,2, 0,1,0);
        v(0,1,2,0, 0,0,0,1);
        rep(2, 1,2, 1,1,0);
        v(0,0,0,0, 0,1,1,0);
        rep(3, 0,0, 0,1,0);
        v(0,0,0,0, 0,0,0,1);

        // requests with width=9 while busy are dropped
        v(0,1,3,0, 0,0,0,1);
        v(0,1,9,0, 1,1,0,0);
        v(0,0,9,0, 1,1,0,0);
        v(0,1,9,0, 1,1,0,0);
        v(0,1,9,0, 0,1,1,0);
        v(0,1,9,0, 0,1,0,0);
        rep(2, 0,9, 0,1,0);
        v(0,0,0,0, 0,0,0,1);
        v(0,0,0,0, 0,0,0,1);

        // reset on cycle 2 of a width=10 pulse
        v(0,1,10,0, 0,0,0,1);
        v(0,0,0,0, 1,1,0,0);
        v(1,0,0,0, 1,1,0,0);
        v(0,0,0,0, 0,0,0,1);
        v(0,0,0,0, 0,0,0,1);

`ifdef SLOW_PULSE_DRIVER_ABORT_EN
        // abort in idle is ignored
        v(0,0,0,1, 0,0,0,1);
        v(0,0,0,0, 0,0,0,1);
        // abort on cycle 3 of width=10, abort during guard ignored
        v(0,1,10,0, 0,0,0,1);
        v(0,0,0,0, 1,1,0,0);
        v(0,0,0,0, 1,1,0,0);
        v(0,0,0,1, 1,1,0,0);
        v(0,0,0,0, 0,1,1,0);
        v(0,0,0,1, 0,1,0,0);
        rep(2, 0,0, 0,1,0);
        v(0,0,0,0, 0,0,0,1);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; start_valid = vq[i].valid;
            width = vq[i].width; abort = vq[i].abort;
            #1;
            chk("out",     i, out0,  vq[i].act);
            chk("busy",    i, busy0, vq[i].busy);
            chk("done",    i, done0, vq[i].done);
            chk("ready",   i, rdy0,  vq[i].ready);
            chk("out_inv", i, out1,  ~vq[i].act);
            chk("busy_inv",i, busy1, vq[i].busy);
            chk("done_inv",i, done1, vq[i].done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
